// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues in-order imem requests, buffers returned
// instructions with their PCs, and presents one per cycle to decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          QDEPTH          = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_F,
  input  logic        Redirect_E,
  input  logic [63:0] PCTarget_E,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [63:0] PC_F,
  output logic [31:0] Instr_F,
  output logic        Valid_F
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + OW + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic [63:0]   req_pc;
  logic [63:0]   resp_pc;
  logic [63:0]   pc_q    [QDEPTH];
  logic [31:0]   instr_q [QDEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [SW-1:0] credit_used;
  logic [63:0]   target_pc;
  logic          empty;
  logic          fire;
  logic          push;
  logic          pop;

  // Credits count queue slots plus every in-flight request that will be kept,
  // so a returning response always has a free slot waiting for it.
  assign credit_used    = SW'(outstanding) - SW'(drop_cnt) + SW'(count);
  assign imem_req_valid = !rst && !Redirect_E
                          && (outstanding < OW'(MAX_OUTSTANDING))
                          && (credit_used < SW'(QDEPTH));
  assign imem_req_addr  = req_pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign empty     = (count == '0);
  assign push      = imem_resp_valid && !Redirect_E && (drop_cnt == '0);
  assign pop       = !empty && !Stall_F && !Redirect_E;
  assign target_pc = PCTarget_E & ~64'h3;

  assign Valid_F = !empty;
  assign PC_F    = empty ? 64'h0 : pc_q[rd_ptr];
  assign Instr_F = empty ? NOP : instr_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc      <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OW'(fire) - OW'(imem_resp_valid);
      if (Redirect_E) begin
        // Everything still in flight after this cycle belongs to the old path.
        req_pc   <= target_pc;
        resp_pc  <= target_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop_cnt <= outstanding - OW'(imem_resp_valid);
      end else begin
        if (fire) req_pc <= req_pc + 64'd4;
        if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
        if (push) begin
          resp_pc <= resp_pc + 64'd4;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_q[wr_ptr]    <= resp_pc;
      instr_q[wr_ptr] <= imem_resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count == CW'(QDEPTH))));
      assert (!(imem_resp_valid && (outstanding == '0)));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-1 instruction memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Stall_F = 1'b0;
  logic        Redirect_E = 1'b0;
  logic [63:0] PCTarget_E = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [63:0] PC_F;
  logic [31:0] Instr_F;
  logic        Valid_F;

  int errors = 0;
  int checks = 0;
  bit mem_hold = 1'b0;
  logic [63:0] pend [$];

  fetch_unit #(.RESET_PC(64'h0), .QDEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .Stall_F(Stall_F), .Redirect_E(Redirect_E),
    .PCTarget_E(PCTarget_E), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .PC_F(PC_F), .Instr_F(Instr_F), .Valid_F(Valid_F)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memdata(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0003;
  endfunction

  // Memory: answers each accepted request on the following clock edge unless held.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pend.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end else if (!mem_hold && pend.size() > 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memdata(pend.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
      #2;
      if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; Stall_F = 1'b0; Redirect_E = 1'b0; PCTarget_E = '0;
    imem_req_ready = 1'b1; mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #3;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (Valid_F !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", Valid_F); end
    checks++; if (PC_F !== 64'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", PC_F); end
    checks++; if (Instr_F !== 32'h00000013) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 00000013", Instr_F); end
  endtask

  task automatic test_startup();
    reset_dut();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #3;
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'(4 * c)) begin errors++; $display("[TB] FAIL startup_req c=%0d: got v=%b a=%h expected v=1 a=%h", c, imem_req_valid, imem_req_addr, 64'(4 * c)); end
      if (c < 2) begin
        checks++; if (Valid_F !== 1'b0) begin errors++; $display("[TB] FAIL startup_valid_low c=%0d: got %b expected 0", c, Valid_F); end
      end else begin
        checks++; if (Valid_F !== 1'b1 || PC_F !== 64'(4 * (c - 2)) || Instr_F !== memdata(64'(4 * (c - 2)))) begin errors++; $display("[TB] FAIL startup_out c=%0d: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", c, Valid_F, PC_F, Instr_F, 64'(4 * (c - 2)), memdata(64'(4 * (c - 2)))); end
      end
    end
  endtask

  task automatic test_stall();
    reset_dut();
    repeat (8) @(negedge clk);
    Stall_F = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #3;
      checks++; if (Valid_F !== 1'b1 || PC_F !== 64'd24 || Instr_F !== memdata(64'd24)) begin errors++; $display("[TB] FAIL stall_hold i=%0d: got v=%b pc=%h i=%h expected pc=18", i, Valid_F, PC_F, Instr_F); end
      if (i >= 3) begin
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_full_req i=%0d: got %b expected 0", i, imem_req_valid); end
      end
    end
    @(negedge clk);
    Stall_F = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #3;
      checks++; if (Valid_F !== 1'b1 || PC_F !== 64'(24 + 4 * k) || Instr_F !== memdata(64'(24 + 4 * k))) begin errors++; $display("[TB] FAIL stall_drain k=%0d: got v=%b pc=%h expected pc=%h", k, Valid_F, PC_F, 64'(24 + 4 * k)); end
    end
  endtask

  task automatic test_ready();
    reset_dut();
    repeat (3) @(negedge clk);
    imem_req_ready = 1'b0;
    #3;
    checks++; if (imem_req_addr !== 64'd12) begin errors++; $display("[TB] FAIL ready_addr0: got %h expected c", imem_req_addr); end
    @(negedge clk); #3;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'd12) begin errors++; $display("[TB] FAIL ready_addr1: got v=%b a=%h expected v=1 a=c", imem_req_valid, imem_req_addr); end
    checks++; if (Valid_F !== 1'b1 || PC_F !== 64'd8) begin errors++; $display("[TB] FAIL ready_out1: got v=%b pc=%h expected v=1 pc=8", Valid_F, PC_F); end
    @(negedge clk); #3;
    checks++; if (imem_req_addr !== 64'd12 || Valid_F !== 1'b0) begin errors++; $display("[TB] FAIL ready_idle2: got a=%h v=%b expected a=c v=0", imem_req_addr, Valid_F); end
    @(negedge clk);
    imem_req_ready = 1'b1;
    #3;
    checks++; if (imem_req_addr !== 64'd12 || Valid_F !== 1'b0) begin errors++; $display("[TB] FAIL ready_idle3: got a=%h v=%b expected a=c v=0", imem_req_addr, Valid_F); end
    @(negedge clk); #3;
    checks++; if (imem_req_addr !== 64'd16 || Valid_F !== 1'b0) begin errors++; $display("[TB] FAIL ready_resume: got a=%h v=%b expected a=10 v=0", imem_req_addr, Valid_F); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b1 || PC_F !== 64'd12 || Instr_F !== memdata(64'd12)) begin errors++; $display("[TB] FAIL ready_out12: got v=%b pc=%h i=%h expected pc=c", Valid_F, PC_F, Instr_F); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b1 || PC_F !== 64'd16) begin errors++; $display("[TB] FAIL ready_out16: got v=%b pc=%h expected pc=10", Valid_F, PC_F); end
  endtask

  task automatic test_redirect();
    reset_dut();
    repeat (3) @(negedge clk);
    Stall_F = 1'b1; mem_hold = 1'b1;
    @(negedge clk);
    Redirect_E = 1'b1; PCTarget_E = 64'h1000;
    #3;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_no_issue: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    Redirect_E = 1'b0; Stall_F = 1'b0; mem_hold = 1'b0;
    #3;
    checks++; if (Valid_F !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flushed: got v=%b rv=%b expected 0 0", Valid_F, imem_req_valid); end
    @(negedge clk); #3;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000 || Valid_F !== 1'b0) begin errors++; $display("[TB] FAIL redir_target_req: got rv=%b a=%h v=%b expected 1 1000 0", imem_req_valid, imem_req_addr, Valid_F); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b0 || imem_req_addr !== 64'h1004) begin errors++; $display("[TB] FAIL redir_drop2: got v=%b a=%h expected 0 1004", Valid_F, imem_req_addr); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b1 || PC_F !== 64'h1000 || Instr_F !== memdata(64'h1000)) begin errors++; $display("[TB] FAIL redir_first: got v=%b pc=%h i=%h expected pc=1000", Valid_F, PC_F, Instr_F); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b1 || PC_F !== 64'h1004) begin errors++; $display("[TB] FAIL redir_second: got v=%b pc=%h expected pc=1004", Valid_F, PC_F); end
  endtask

  task automatic test_redirect_stall_resp();
    reset_dut();
    repeat (3) @(negedge clk);
    Stall_F = 1'b1; mem_hold = 1'b1;
    @(negedge clk);
    Redirect_E = 1'b1; PCTarget_E = 64'h2003; mem_hold = 1'b0;
    #3;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rsr_no_issue: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    Redirect_E = 1'b0; Stall_F = 1'b0;
    #3;
    checks++; if (Valid_F !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin errors++; $display("[TB] FAIL rsr_aligned_req: got v=%b rv=%b a=%h expected 0 1 2000", Valid_F, imem_req_valid, imem_req_addr); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b0) begin errors++; $display("[TB] FAIL rsr_drop_one: got v=%b pc=%h expected v=0", Valid_F, PC_F); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b1 || PC_F !== 64'h2000 || Instr_F !== memdata(64'h2000)) begin errors++; $display("[TB] FAIL rsr_first: got v=%b pc=%h i=%h expected pc=2000", Valid_F, PC_F, Instr_F); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    repeat (3) @(negedge clk);
    Redirect_E = 1'b1; PCTarget_E = 64'h100; mem_hold = 1'b1;
    #3;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_issue: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    PCTarget_E = 64'h200;
    #3;
    checks++; if (Valid_F !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second: got v=%b rv=%b expected 0 0", Valid_F, imem_req_valid); end
    @(negedge clk);
    Redirect_E = 1'b0; mem_hold = 1'b0;
    #3;
    checks++; if (Valid_F !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h200) begin errors++; $display("[TB] FAIL b2b_req: got v=%b rv=%b a=%h expected 0 1 200", Valid_F, imem_req_valid, imem_req_addr); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b0 || imem_req_addr !== 64'h204) begin errors++; $display("[TB] FAIL b2b_drop: got v=%b a=%h expected 0 204", Valid_F, imem_req_addr); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b1 || PC_F !== 64'h200 || Instr_F !== memdata(64'h200)) begin errors++; $display("[TB] FAIL b2b_first: got v=%b pc=%h i=%h expected pc=200", Valid_F, PC_F, Instr_F); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b1 || PC_F !== 64'h204) begin errors++; $display("[TB] FAIL b2b_next: got v=%b pc=%h expected pc=204", Valid_F, PC_F); end
  endtask

  task automatic test_wrap();
    reset_dut();
    @(negedge clk);
    Redirect_E = 1'b1; PCTarget_E = 64'hFFFF_FFFF_FFFF_FFF8;
    @(negedge clk);
    Redirect_E = 1'b0;
    #3;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_req0: got rv=%b a=%h expected fff..ff8", imem_req_valid, imem_req_addr); end
    @(negedge clk); #3;
    checks++; if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_req1: got %h expected fff..ffc", imem_req_addr); end
    @(negedge clk); #3;
    checks++; if (imem_req_addr !== 64'h0 || Valid_F !== 1'b1 || PC_F !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_req2: got a=%h v=%b pc=%h expected a=0 pc=fff..ff8", imem_req_addr, Valid_F, PC_F); end
    @(negedge clk); #3;
    checks++; if (PC_F !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_out1: got %h expected fff..ffc", PC_F); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b1 || PC_F !== 64'h0 || Instr_F !== memdata(64'h0)) begin errors++; $display("[TB] FAIL wrap_out2: got v=%b pc=%h i=%h expected pc=0", Valid_F, PC_F, Instr_F); end
  endtask

  task automatic test_reset_midop();
    reset_dut();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #3;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req: got %b expected 0", imem_req_valid); end
    @(negedge clk); #3;
    checks++; if (Valid_F !== 1'b0 || PC_F !== 64'h0 || Instr_F !== 32'h00000013) begin errors++; $display("[TB] FAIL midreset_out: got v=%b pc=%h i=%h expected 0 0 00000013", Valid_F, PC_F, Instr_F); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_ready();
    test_redirect();
    test_redirect_stall_resp();
    test_back_to_back();
    test_wrap();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
